// File: rtl/implication_monitor.sv
// Run-time checker for "a implies b" with overlapped (DELAY=0) or delayed consequent.
// Counts pass/fail/vacuous evaluations and stamps the cycle of the first failure.
module implication_monitor #(
  parameter int DELAY = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic             fail_seen,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] vac_cnt,
  output logic [CNT_W-1:0] first_fail_time,
  output logic [CNT_W-1:0] cycle_cnt
);

  logic ante;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Antecedent seen by the evaluator: live a, or the bit pushed DELAY enabled edges ago
  generate
    if (DELAY == 0) begin : g_overlap
      assign ante = a;
    end else begin : g_pipe
      logic [DELAY-1:0] pipe;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe <= '0;
        end else if (clr) begin
          pipe <= '0;
        end else if (en) begin
          pipe[0] <= a;
          for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign ante = pipe[DELAY-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt       <= '0;
      pass_pulse      <= 1'b0;
      fail_pulse      <= 1'b0;
      fail_seen       <= 1'b0;
      pass_cnt        <= '0;
      fail_cnt        <= '0;
      vac_cnt         <= '0;
      first_fail_time <= '0;
    end else begin
      cycle_cnt  <= cycle_cnt + CNT_W'(1);
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
      if (clr) begin
        fail_seen       <= 1'b0;
        pass_cnt        <= '0;
        fail_cnt        <= '0;
        vac_cnt         <= '0;
        first_fail_time <= '0;
      end else if (en) begin
        if (!a) vac_cnt <= sat_inc(vac_cnt);
        if (ante) begin
          if (b) begin
            pass_pulse <= 1'b1;
            pass_cnt   <= sat_inc(pass_cnt);
          end else begin
            fail_pulse <= 1'b1;
            fail_cnt   <= sat_inc(fail_cnt);
            // Stamp is the pre-increment cycle count, captured only once
            if (!fail_seen) begin
              fail_seen       <= 1'b1;
              first_fail_time <= cycle_cnt;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_implication_monitor.sv
// Scoreboard bench for implication_monitor: four instances (DELAY 0/1/2 and a 4-bit
// counter variant) share stimulus; expected pulses are queued and popped by a monitor.
module tb_implication_monitor;

  logic clk, rst_n, en, clr, a, b;
  logic [3:0] pp, fp, fs;
  logic [3:0][15:0] pc, fc, vc, ft, cc;
  logic [3:0] pc3, fc3, vc3, ft3, cc3;
  logic [1:0] sel;
  int checks, failures;
  int exp_q[$];

  logic m_pp, m_fp, m_fs;
  logic [15:0] m_pc, m_fc, m_vc, m_ft, m_cc;

  always_comb begin
    m_pp = pp[sel];
    m_fp = fp[sel];
    m_fs = fs[sel];
    m_pc = pc[sel];
    m_fc = fc[sel];
    m_vc = vc[sel];
    m_ft = ft[sel];
    m_cc = cc[sel];
  end

  implication_monitor #(.DELAY(0), .CNT_W(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
    .pass_pulse(pp[0]), .fail_pulse(fp[0]), .fail_seen(fs[0]),
    .pass_cnt(pc[0]), .fail_cnt(fc[0]), .vac_cnt(vc[0]),
    .first_fail_time(ft[0]), .cycle_cnt(cc[0]));

  implication_monitor #(.DELAY(1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
    .pass_pulse(pp[1]), .fail_pulse(fp[1]), .fail_seen(fs[1]),
    .pass_cnt(pc[1]), .fail_cnt(fc[1]), .vac_cnt(vc[1]),
    .first_fail_time(ft[1]), .cycle_cnt(cc[1]));

  implication_monitor #(.DELAY(2), .CNT_W(16)) u_d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
    .pass_pulse(pp[2]), .fail_pulse(fp[2]), .fail_seen(fs[2]),
    .pass_cnt(pc[2]), .fail_cnt(fc[2]), .vac_cnt(vc[2]),
    .first_fail_time(ft[2]), .cycle_cnt(cc[2]));

  implication_monitor #(.DELAY(0), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
    .pass_pulse(pp[3]), .fail_pulse(fp[3]), .fail_seen(fs[3]),
    .pass_cnt(pc3), .fail_cnt(fc3), .vac_cnt(vc3),
    .first_fail_time(ft3), .cycle_cnt(cc3));

  assign pc[3] = {12'h0, pc3};
  assign fc[3] = {12'h0, fc3};
  assign vc[3] = {12'h0, vc3};
  assign ft[3] = {12'h0, ft3};
  assign cc[3] = {12'h0, cc3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  // exp: 0 = no evaluation, 1 = pass, 2 = fail at this edge
  task automatic step(input logic ia, input logic ib, input logic ien, input logic iclr,
                      input int exp);
    a = ia; b = ib; en = ien; clr = iclr;
    if (exp != 0) exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a = 1'b0; b = 1'b0; en = 1'b0; clr = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic flush_check(input string nm);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk({nm, "_pending"}, 16'(exp_q.size()), 16'd0);
    exp_q.delete();
  endtask

  // Monitor: every pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && (m_pp || m_fp)) begin
      int got;
      got = m_pp ? 1 : 2;
      checks++;
      if (m_pp && m_fp) begin
        failures++;
        $display("FAIL both_pulses: pass_pulse=1 fail_pulse=1 required at most one (t=%0t)", $time);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: got kind %0d expected none (t=%0t)", got, $time);
      end else begin
        int want;
        want = exp_q.pop_front();
        if (got != want) begin
          failures++;
          $display("FAIL pulse_kind: got %0d expected %0d (t=%0t)", got, want, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; sel = 2'd0;
    rst_n = 1'b0; a = 1'b0; b = 1'b0; en = 1'b0; clr = 1'b0;

    // Reset held 3 cycles while a/b toggle
    for (int i = 0; i < 3; i++) begin
      a = ~a; b = (i == 1); en = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_outputs", 16'({m_pp, m_fp, m_fs, |m_pc, |m_fc, |m_vc, |m_ft, |m_cc}), 16'd0);
    end
    a = 1'b0; b = 1'b0; en = 1'b0;
    rst_n = 1'b1;

    // Overlapped, DELAY=0
    sel = 2'd0;
    step(0, 0, 1, 0, 0);
    chk("ovl_cycle_after_first_edge", m_cc, 16'd1);
    step(1, 1, 1, 0, 1);
    step(1, 0, 1, 0, 2);
    chk("ovl_fail_pulse", {15'd0, m_fp}, 16'd1);
    chk("ovl_first_fail_time", m_ft, 16'd2);
    chk("ovl_fail_seen", {15'd0, m_fs}, 16'd1);
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 1);
    chk("ovl_vac", m_vc, 16'd2);
    chk("ovl_pass", m_pc, 16'd2);
    chk("ovl_fail", m_fc, 16'd1);
    chk("ovl_fail_seen_sticky", {15'd0, m_fs}, 16'd1);
    chk("ovl_ftime_hold", m_ft, 16'd2);
    flush_check("ovl");

    // Delayed, DELAY=2: single antecedent passing
    sel = 2'd2;
    do_reset();
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    chk("dly_pass", m_pc, 16'd1);
    chk("dly_fail", m_fc, 16'd0);
    chk("dly_vac", m_vc, 16'd3);
    flush_check("dly_pass");

    // Delayed, DELAY=2: single antecedent failing
    do_reset();
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 2);
    chk("dly_fail_cnt", m_fc, 16'd1);
    chk("dly_first_fail_time", m_ft, 16'd3);
    chk("dly_fail_pass_cnt", m_pc, 16'd0);
    flush_check("dly_fail");

    // Back-to-back antecedents, DELAY=2
    do_reset();
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 1);
    step(0, 0, 1, 0, 2);
    step(0, 1, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    chk("b2b_pass", m_pc, 16'd2);
    chk("b2b_fail", m_fc, 16'd1);
    chk("b2b_ftime", m_ft, 16'd4);
    chk("b2b_vac", m_vc, 16'd3);
    flush_check("b2b");

    // Reset mid-delay drops the pending antecedent
    do_reset();
    step(1, 0, 1, 0, 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("rst_mid_fail", m_fc, 16'd0);
    chk("rst_mid_vac", m_vc, 16'd3);
    flush_check("rst_mid");

    // en gating and clr, DELAY=1
    sel = 2'd1;
    do_reset();
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1);
    chk("en_pass", m_pc, 16'd1);
    chk("en_vac", m_vc, 16'd1);
    chk("en_fail", m_fc, 16'd0);
    step(1, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    chk("clr_fail_cnt", m_fc, 16'd0);
    chk("clr_fail_seen", {15'd0, m_fs}, 16'd0);
    chk("clr_fail_pulse", {15'd0, m_fp}, 16'd0);
    chk("clr_pass_cnt", m_pc, 16'd0);
    chk("clr_cycle_kept", m_cc, 16'd6);
    step(0, 0, 1, 0, 0);
    chk("clr_pipe_empty_fail", m_fc, 16'd0);
    chk("clr_vac_after", m_vc, 16'd1);
    flush_check("enclr");

    // Saturation, CNT_W=4
    sel = 2'd3;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      step(1, 1, 1, 0, 1);
      chk("sat_pass_cnt", m_pc, 16'((k > 15) ? 15 : k));
      chk("sat_pulse", {15'd0, m_pp}, 16'd1);
      chk("sat_cycle", m_cc, 16'(k % 16));
    end
    flush_check("sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/implication_monitor.md
Name: implication_monitor

Overview:
- Synthesizable run-time checker for the property "a implies b", with either overlapped (same-cycle) or delayed consequent evaluation.
- Sits directly downstream of the a/b request-response signals that the assertion benches check, and consumes the same pair in silicon.
- Counts pass, fail and vacuous evaluations, and latches the cycle stamp of the first failure.
- Results are exposed for status registers and for cross-checking against the simulation assertion.

Parameters:
- DELAY, 0, consequent offset in cycles: 0 = overlapped (a |-> b), N>0 = a |-> ##N b; legal range 0..15.
- CNT_W, 16, width of the pass/fail/vacuous counters and the cycle counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  sampling enable; low freezes antecedent pipeline and evaluation
- clr  in  1  synchronous clear of counters, sticky flag, stamp and pipeline
- a  in  1  antecedent
- b  in  1  consequent
- pass_pulse  out  1  one-cycle pulse per passing evaluation
- fail_pulse  out  1  one-cycle pulse per failing evaluation
- fail_seen  out  1  sticky failure flag
- pass_cnt  out  CNT_W  saturating pass count
- fail_cnt  out  CNT_W  saturating fail count
- vac_cnt  out  CNT_W  saturating vacuous count (antecedent low when sampled)
- first_fail_time  out  CNT_W  cycle_cnt value at first failing evaluation
- cycle_cnt  out  CNT_W  free-running cycle counter, wraps

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, antecedent pipeline 0, cycle_cnt 0.
- cycle_cnt increments every clk edge regardless of en/clr, wraps at all-ones to 0.
- Sampling, en=1: at each edge, a is sampled.
  - a=0 increments vac_cnt at that edge for any DELAY.
  - DELAY=0: evaluation happens at the same edge. a&b is a pass; a&~b is a fail.
  - DELAY=N>0: a is pushed into an N-deep shift register. When the bit sampled N enabled edges earlier reaches the output stage, b is evaluated at the current edge: b=1 is a pass, b=0 is a fail.
  - Several outstanding antecedents are tracked independently, one per stage.
- en=0: no push, no shift, no evaluation, no vac count. The pipeline holds its state, so delay counts only enabled edges.
- Pulses are registered. pass_pulse/fail_pulse are high in the cycle following the evaluating edge, for exactly one cycle, and never both high.
- Counter update: the counters update at the evaluating edge, so the new value is visible in the same cycle as the pulse. Each counter saturates at 2^CNT_W-1 and never wraps.
- First failure: fail_seen sets on the first failing evaluation. first_fail_time captures cycle_cnt as it was before that edge's increment; later failures do not change it.
- clr=1:
  - Zeroes pass_cnt, fail_cnt, vac_cnt, fail_seen, first_fail_time and the pipeline; pulses are 0 in the next cycle.
  - clr beats a simultaneous evaluation: that evaluation is discarded.
  - clr does not clear cycle_cnt.
- Reset asserted mid-delay drops pending antecedents with no pulse. After release, evaluation begins fresh.
- Overflow: when cycle_cnt wraps, first_fail_time is still the raw stamp; software handles the ambiguity.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles, toggling a/b -> all outputs 0; release -> cycle_cnt reaches 1 after the first edge.
- Overlapped mode (DELAY=0, en=1): edge sequence (a,b) = (0,0),(1,1),(1,0),(0,1),(1,1) -> vac_cnt=2, pass_cnt=2, fail_cnt=1.
  - fail_pulse appears in the cycle after the third edge.
  - first_fail_time=2, fail_seen=1, and it stays 1 after the later pass.
- Delayed mode (DELAY=2): a=1 at edge 1 only; b=0 at edge 2, b=1 at edge 3 -> exactly one pass at edge 3, no fail.
  - Repeat with b=0 at edge 3 -> fail_cnt=1, first_fail_time=3.
- Back-to-back (DELAY=2): a=1 on edges 1,2,3; b=1 at edges 3 and 5, b=0 at edge 4 -> pulse order pass, fail, pass; pass_cnt=2, fail_cnt=1.
- en/clr (DELAY=1): a=1 at edge 1, en=0 for edges 2–3, b=1 at edge 4 with en=1 -> pass at edge 4.
  - Separately, assert clr on a failing evaluation edge -> fail_cnt=0, fail_seen=0, no fail_pulse.
- Saturation (CNT_W=4): 20 consecutive a=1,b=1 edges -> pass_cnt holds at 15, with pass_pulse still firing every cycle.
  - cycle_cnt wraps to 0 after 16 edges.
